// File: rtl/lowf_queue_seq_pkg.sv
// Shared constants and types for the low-frequency sample queue sequencer.
package lowf_seq_pkg;

    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int WIN_LEN = 1021;
    localparam int DECIM   = 2;
    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef logic [ADDR_W-1:0]  qaddr_t;
    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam qaddr_t WIN_FULL   = qaddr_t'(WIN_LEN);
    localparam qaddr_t WIN_LAST   = qaddr_t'(WIN_LEN - 1);
    localparam phase_t PHASE_LAST = phase_t'(DECIM - 1);

endpackage

// File: rtl/lowf_queue_seq_if.sv
// Sample-strobe / RAM-control bundle between the sample source and the queue sequencer.
interface lowf_queue_seq_if;
    import lowf_seq_pkg::*;

    logic   wrt_smpl;
    logic   flush;
    logic   we;
    qaddr_t waddr;
    qaddr_t raddr;
    logic   sequencing;
    logic   smpl_vld;
    logic   seq_done;
    logic   full;
    logic   overrun;

    modport master (
        output wrt_smpl, flush,
        input  we, waddr, raddr, sequencing, smpl_vld, seq_done, full, overrun
    );

    modport slave (
        input  wrt_smpl, flush,
        output we, waddr, raddr, sequencing, smpl_vld, seq_done, full, overrun
    );

endinterface

// File: rtl/lowf_queue_seq_burst_gen.sv
// Read-burst engine: sweeps raddr over one window per request, queues one extra request.
//   state | meaning
//   IDLE  | no burst, waiting for a request or a pending one
//   RUN   | raddr carries a valid window address, WIN_LEN cycles
//   DONE  | one-cycle seq_done pulse, relaunch if pending
module lowf_burst_gen
    import lowf_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   start_i,
    input  qaddr_t start_addr_i,
    output qaddr_t raddr_o,
    output logic   sequencing_o,
    output logic   smpl_vld_o,
    output logic   seq_done_o,
    output logic   overrun_o
);

    seq_state_t state_q, state_d;
    qaddr_t     raddr_q;
    qaddr_t     bcnt_q;
    logic       pend_q, pend_d;
    logic       ovr_q, ovr_d;
    logic       smpl_vld_q;
    logic       launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i || pend_q) begin
                        state_d = RUN;
                        launch  = 1'b1;
                    end
                end
                RUN: begin
                    if (bcnt_q == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (pend_q) begin
                        state_d = RUN;
                        launch  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sequencing_o = (state_q == RUN);
        seq_done_o   = (state_q == DONE);
    end

    // Only one request can wait behind the active burst; a second one is lost.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (flush_i) begin
            pend_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (launch) begin
                pend_d = 1'b0;
            end
        end else begin
            if (launch) begin
                pend_d = 1'b0;
            end
            if (start_i) begin
                if (pend_q) begin
                    ovr_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q    <= '0;
            bcnt_q     <= '0;
            pend_q     <= 1'b0;
            smpl_vld_q <= 1'b0;
        end else if (flush_i) begin
            raddr_q    <= '0;
            bcnt_q     <= '0;
            pend_q     <= 1'b0;
            smpl_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            smpl_vld_q <= (state_q == RUN);
            if (launch) begin
                raddr_q <= start_addr_i;
                bcnt_q  <= WIN_LAST;
            end else if ((state_q == RUN) && (bcnt_q != '0)) begin
                raddr_q <= raddr_q + qaddr_t'(1);
                bcnt_q  <= bcnt_q - qaddr_t'(1);
            end
        end
    end

    // Overrun survives flush so software can still see that data was lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign raddr_o    = raddr_q;
    assign smpl_vld_o = smpl_vld_q;
    assign overrun_o  = ovr_q;

endmodule

// File: rtl/lowf_queue_seq.sv
// Low-frequency queue sequencer: decimated RAM writes, fill tracking, sliding-window
// oldest pointer, and burst launch towards the FIR read engine.
module lowf_queue_seq
    import lowf_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    lowf_queue_seq_if.slave  bus
);

    phase_t phase_q, phase_d;
    qaddr_t new_ptr_q, new_ptr_d;
    qaddr_t old_ptr_q, old_ptr_d;
    qaddr_t cnt_q, cnt_d;
    logic   req_q, req_d;
    logic   qual;
    logic   full;

    assign full = (cnt_q == WIN_FULL);
    assign qual = bus.wrt_smpl && !bus.flush && (phase_q == PHASE_LAST);

    always_comb begin
        phase_d   = phase_q;
        new_ptr_d = new_ptr_q;
        old_ptr_d = old_ptr_q;
        cnt_d     = cnt_q;
        if (bus.wrt_smpl && !bus.flush) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + phase_t'(1);
        end
        if (qual) begin
            new_ptr_d = new_ptr_q + qaddr_t'(1);
            if (full) begin
                old_ptr_d = old_ptr_q + qaddr_t'(1);
            end else begin
                cnt_d = cnt_q + qaddr_t'(1);
            end
        end
        req_d = qual && (cnt_d == WIN_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            new_ptr_q <= '0;
            old_ptr_q <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
        end else if (bus.flush) begin
            phase_q   <= '0;
            new_ptr_q <= '0;
            old_ptr_q <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            new_ptr_q <= new_ptr_d;
            old_ptr_q <= old_ptr_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
        end
    end

    // The request lands one cycle after the write, so old_ptr_q is already post-update.
    lowf_burst_gen u_burst (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.flush),
        .start_i      (req_q),
        .start_addr_i (old_ptr_q),
        .raddr_o      (bus.raddr),
        .sequencing_o (bus.sequencing),
        .smpl_vld_o   (bus.smpl_vld),
        .seq_done_o   (bus.seq_done),
        .overrun_o    (bus.overrun)
    );

    assign bus.we    = qual;
    assign bus.waddr = new_ptr_q;
    assign bus.full  = full;

endmodule
